// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge
//   Converts the core's SRAM-style instruction and data ports into a single
//   AXI master with one outstanding transaction. The pipeline is held via
//   stallreq while a transaction is in flight. Read data is registered, so it
//   appears in the cycle after the response, which matches the core's
//   "rdata next cycle" behaviour. When both ports request together, the data
//   access is served first.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   inst_sram_*                   instruction fetch port (always a read)
//   data_sram_*                   load/store port (wen != 0 means store)
//   stallreq                      freeze request to the core's stall controller
//   ar*/r*                        AXI read address / read data channels
//   aw*/w*/b*                     AXI write address / write data / response
module sram_axi_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, D_AR, D_R, D_W, D_B, I_AR, I_R} state_t;

  state_t      state_reg, state_next;
  logic        d_pend_reg, i_pend_reg;
  logic [31:0] d_addr_reg, d_wdata_reg, i_addr_reg;
  logic [3:0]  d_wen_reg;
  logic        aw_done_reg, w_done_reg;
  logic [31:0] inst_rdata_reg, data_rdata_reg;

  logic        capture;
  logic        d_r_fire, i_r_fire, b_fire;

  // The fetch port never writes and only one transaction is outstanding,
  // so these inputs carry no information for the bridge.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wen, inst_sram_wdata, rid};

  assign arsize          = 3'd2;
  assign awsize          = 3'd2;
  assign awaddr          = d_addr_reg;
  assign wdata           = d_wdata_reg;
  assign wstrb           = d_wen_reg;
  assign inst_sram_rdata = inst_rdata_reg;
  assign data_sram_rdata = data_rdata_reg;

  // Next state, AXI controls and stallreq. AXI valid/ready outputs depend only
  // on registered state, never on AXI inputs; stallreq alone may follow the
  // response handshake combinationally so the core advances in that cycle.
  always_comb begin
    state_next = state_reg;
    arvalid    = 1'b0;
    arid       = 4'd0;
    araddr     = i_addr_reg;
    rready     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    stallreq   = 1'b1;
    capture    = 1'b0;
    d_r_fire   = 1'b0;
    i_r_fire   = 1'b0;
    b_fire     = 1'b0;
    case (state_reg)
      IDLE: begin
        stallreq = (inst_sram_en | data_sram_en) & ~rst;
        if (inst_sram_en | data_sram_en) begin
          capture = 1'b1;
          if (data_sram_en)
            state_next = (|data_sram_wen) ? D_W : D_AR;
          else
            state_next = I_AR;
        end
      end
      D_AR: begin
        arvalid = 1'b1;
        arid    = 4'd1;
        araddr  = d_addr_reg;
        if (arready) state_next = D_R;
      end
      D_R: begin
        rready = 1'b1;
        if (rvalid) begin
          d_r_fire   = 1'b1;
          stallreq   = i_pend_reg;
          state_next = i_pend_reg ? I_AR : IDLE;
        end
      end
      D_W: begin
        awvalid = ~aw_done_reg;
        wvalid  = ~w_done_reg;
        // Each channel may complete in a different cycle; leave once both have.
        if ((aw_done_reg | awready) && (w_done_reg | wready))
          state_next = D_B;
      end
      D_B: begin
        bready = 1'b1;
        if (bvalid) begin
          b_fire     = 1'b1;
          stallreq   = i_pend_reg;
          state_next = i_pend_reg ? I_AR : IDLE;
        end
      end
      I_AR: begin
        arvalid = 1'b1;
        if (arready) state_next = I_R;
      end
      I_R: begin
        rready = 1'b1;
        if (rvalid) begin
          i_r_fire   = 1'b1;
          // Data is always served first, so d_pend is already clear here.
          stallreq   = d_pend_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      d_pend_reg     <= 1'b0;
      i_pend_reg     <= 1'b0;
      d_addr_reg     <= 32'd0;
      d_wdata_reg    <= 32'd0;
      d_wen_reg      <= 4'd0;
      i_addr_reg     <= 32'd0;
      aw_done_reg    <= 1'b0;
      w_done_reg     <= 1'b0;
      inst_rdata_reg <= 32'd0;
      data_rdata_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        d_pend_reg  <= data_sram_en;
        i_pend_reg  <= inst_sram_en;
        d_addr_reg  <= data_sram_addr;
        d_wen_reg   <= data_sram_wen;
        d_wdata_reg <= data_sram_wdata;
        i_addr_reg  <= inst_sram_addr;
      end
      if (d_r_fire) begin
        data_rdata_reg <= rdata;
        d_pend_reg     <= 1'b0;
      end
      if (b_fire) d_pend_reg <= 1'b0;
      if (i_r_fire) begin
        inst_rdata_reg <= rdata;
        i_pend_reg     <= 1'b0;
      end
      // Per-channel completion flags, only meaningful while in D_W.
      if (state_reg == D_W) begin
        if (awvalid && awready) aw_done_reg <= 1'b1;
        if (wvalid && wready)   w_done_reg  <= 1'b1;
      end else begin
        aw_done_reg <= 1'b0;
        w_done_reg  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic        stallreq;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic        bvalid, bready;

  int compared   = 0;
  int mismatched = 0;
  int ar_hs      = 0;

  always #5 clk = ~clk;

  sram_axi_bridge dut (
    .clk(clk), .rst(rst),
    .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata),
    .stallreq(stallreq),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  // Advance to 1 time unit after the next rising edge, where inputs change.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    inst_sram_en = 0; inst_sram_wen = 0; inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_en = 0; data_sram_wen = 0; data_sram_addr = 0; data_sram_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    tick(); tick();
    rst = 1'b0; #1;
    chk("rst_stall", {31'd0, stallreq}, 0);
    chk("rst_valids", {27'd0, arvalid, awvalid, wvalid, rready, bready}, 0);
    chk("rst_inst_rdata", inst_sram_rdata, 0);
    chk("rst_data_rdata", data_sram_rdata, 0);

    // ---- 1: instruction fetch, zero-wait slave ----
    $display("txn 1: fetch 0xBFC00000");
    tick();
    inst_sram_en = 1; inst_sram_addr = 32'hBFC00000; #1;
    chk("f1_t_stall", {31'd0, stallreq}, 1);
    chk("f1_t_arvalid", {31'd0, arvalid}, 0);
    tick(); arready = 1; #1;
    chk("f1_ar_valid", {31'd0, arvalid}, 1);
    chk("f1_ar_id", {28'd0, arid}, 0);
    chk("f1_ar_addr", araddr, 32'hBFC00000);
    chk("f1_ar_size", {29'd0, arsize}, 2);
    chk("f1_ar_stall", {31'd0, stallreq}, 1);
    tick(); arready = 0; rvalid = 1; rdata = 32'h3C1D0001; #1;
    chk("f1_r_ready", {31'd0, rready}, 1);
    chk("f1_r_arvalid", {31'd0, arvalid}, 0);
    chk("f1_r_stall", {31'd0, stallreq}, 0);
    tick(); rvalid = 0; inst_sram_en = 0; #1;
    chk("f1_rdata", inst_sram_rdata, 32'h3C1D0001);
    chk("f1_idle_stall", {31'd0, stallreq}, 0);

    // ---- 2: store, wready 3 cycles after awready ----
    $display("txn 2: store 0x80000010 wen=0011");
    data_sram_en = 1; data_sram_wen = 4'b0011;
    data_sram_addr = 32'h80000010; data_sram_wdata = 32'h12345678; #1;
    chk("st_t_stall", {31'd0, stallreq}, 1);
    tick(); awready = 1; #1;
    chk("st_aw_valid", {31'd0, awvalid}, 1);
    chk("st_w_valid1", {31'd0, wvalid}, 1);
    chk("st_wstrb", {28'd0, wstrb}, 4'b0011);
    chk("st_awaddr", awaddr, 32'h80000010);
    chk("st_wdata", wdata, 32'h12345678);
    chk("st_awsize", {29'd0, awsize}, 2);
    chk("st_stall1", {31'd0, stallreq}, 1);
    tick(); awready = 0; #1;
    chk("st_aw_drop", {31'd0, awvalid}, 0);
    chk("st_w_valid2", {31'd0, wvalid}, 1);
    tick(); #1;
    chk("st_w_valid3", {31'd0, wvalid}, 1);
    chk("st_stall3", {31'd0, stallreq}, 1);
    tick(); wready = 1; #1;
    chk("st_w_valid4", {31'd0, wvalid}, 1);
    chk("st_stall4", {31'd0, stallreq}, 1);
    tick(); wready = 0; bvalid = 1; #1;
    chk("st_w_drop", {31'd0, wvalid}, 0);
    chk("st_bready", {31'd0, bready}, 1);
    chk("st_b_stall", {31'd0, stallreq}, 0);
    tick(); bvalid = 0; data_sram_en = 0; data_sram_wen = 0; #1;
    chk("st_idle_bready", {31'd0, bready}, 0);
    chk("st_idle_stall", {31'd0, stallreq}, 0);

    // ---- 3: simultaneous load and fetch ----
    $display("txn 3: load 0x80000020 + fetch 0xBFC00004");
    data_sram_en = 1; data_sram_addr = 32'h80000020;
    inst_sram_en = 1; inst_sram_addr = 32'hBFC00004; #1;
    chk("sim_t_stall", {31'd0, stallreq}, 1);
    tick(); arready = 1; #1;
    chk("sim_dar_valid", {31'd0, arvalid}, 1);
    chk("sim_dar_id", {28'd0, arid}, 1);
    chk("sim_dar_addr", araddr, 32'h80000020);
    chk("sim_dar_stall", {31'd0, stallreq}, 1);
    tick(); arready = 0; rvalid = 1; rdata = 32'hDEADBEEF; #1;
    chk("sim_dr_ready", {31'd0, rready}, 1);
    chk("sim_dr_stall", {31'd0, stallreq}, 1);
    tick(); rvalid = 0; arready = 1; #1;
    chk("sim_d_rdata", data_sram_rdata, 32'hDEADBEEF);
    chk("sim_iar_valid", {31'd0, arvalid}, 1);
    chk("sim_iar_id", {28'd0, arid}, 0);
    chk("sim_iar_addr", araddr, 32'hBFC00004);
    chk("sim_iar_stall", {31'd0, stallreq}, 1);
    tick(); arready = 0; rvalid = 1; rdata = 32'h00000000; #1;
    chk("sim_ir_stall", {31'd0, stallreq}, 0);
    chk("sim_d_hold1", data_sram_rdata, 32'hDEADBEEF);
    tick(); rvalid = 0; inst_sram_en = 0; data_sram_en = 0; #1;
    chk("sim_i_rdata", inst_sram_rdata, 32'h00000000);
    chk("sim_d_hold2", data_sram_rdata, 32'hDEADBEEF);

    // ---- 4: back-to-back fetches, arready held high ----
    $display("txn 4: fetches 0xBFC00000, 0xBFC00004");
    arready = 1; inst_sram_en = 1; inst_sram_addr = 32'hBFC00000; #1;
    ar_hs += int'(arvalid & arready);
    tick(); #1;
    ar_hs += int'(arvalid & arready);
    chk("bb_ar1_addr", araddr, 32'hBFC00000);
    tick(); rvalid = 1; rdata = 32'h11111111; #1;
    ar_hs += int'(arvalid & arready);
    chk("bb_r1_stall", {31'd0, stallreq}, 0);
    tick(); rvalid = 0; inst_sram_addr = 32'hBFC00004; #1;
    ar_hs += int'(arvalid & arready);
    chk("bb_no_dup", {31'd0, arvalid}, 0);
    chk("bb_rdata1", inst_sram_rdata, 32'h11111111);
    chk("bb_t2_stall", {31'd0, stallreq}, 1);
    tick(); #1;
    ar_hs += int'(arvalid & arready);
    chk("bb_ar2_addr", araddr, 32'hBFC00004);
    tick(); rvalid = 1; rdata = 32'h22222222; #1;
    ar_hs += int'(arvalid & arready);
    chk("bb_r2_stall", {31'd0, stallreq}, 0);
    tick(); rvalid = 0; inst_sram_en = 0; arready = 0; #1;
    ar_hs += int'(arvalid & arready);
    chk("bb_rdata2", inst_sram_rdata, 32'h22222222);
    chk("bb_ar_count", ar_hs, 2);

    // ---- 5: W completes before AW ----
    $display("txn 5: store 0x80000040 wen=1111, W before AW");
    data_sram_en = 1; data_sram_wen = 4'hF;
    data_sram_addr = 32'h80000040; data_sram_wdata = 32'hA5A5A5A5;
    tick(); wready = 1; #1;
    chk("wf_aw_valid", {31'd0, awvalid}, 1);
    chk("wf_w_valid", {31'd0, wvalid}, 1);
    tick(); wready = 0; awready = 1; #1;
    chk("wf_w_drop", {31'd0, wvalid}, 0);
    chk("wf_aw_held", {31'd0, awvalid}, 1);
    chk("wf_stall", {31'd0, stallreq}, 1);
    tick(); awready = 0; bvalid = 1; #1;
    chk("wf_bready", {31'd0, bready}, 1);
    chk("wf_b_stall", {31'd0, stallreq}, 0);
    tick(); bvalid = 0; data_sram_en = 0; data_sram_wen = 0; #1;

    // ---- 6: reset pulsed during D_R, late response ----
    $display("txn 6: load 0x80000030 with reset in D_R");
    data_sram_en = 1; data_sram_addr = 32'h80000030;
    tick(); arready = 1; #1;
    tick(); arready = 0; rst = 1; data_sram_en = 0; #1;
    chk("rr_dr_ready", {31'd0, rready}, 1);
    tick(); rst = 0; rvalid = 1; rdata = 32'hCAFEBABE; #1;
    chk("rr_rready", {31'd0, rready}, 0);
    chk("rr_stall", {31'd0, stallreq}, 0);
    chk("rr_valids", {27'd0, arvalid, awvalid, wvalid, rready, bready}, 0);
    chk("rr_inst_rdata", inst_sram_rdata, 0);
    chk("rr_data_rdata", data_sram_rdata, 0);
    tick(); rvalid = 0; #1;
    chk("rr_not_captured", data_sram_rdata, 0);
    chk("rr_idle_arvalid", {31'd0, arvalid}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sram_axi_bridge.md
# sram_axi_bridge

Memory-side neighbour of the CPU core: converts the core's synchronous SRAM-style instruction and data ports into a single AXI master. It holds the pipeline stalled while a transaction is outstanding and presents read data in the cycle after completion, matching the core's "rdata next cycle" convention. `stallreq` is an additional stall source ORed into the core's stall controller alongside the ID and EX requests.

## Interface
Parameters:
- none (32-bit address/data, word accesses only)

Ports:
- clk  in  1  core clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- inst_sram_en  in  1  instruction request
- inst_sram_wen  in  4  byte write enables; always 0 from IF, treated as a read
- inst_sram_addr  in  32  fetch address
- inst_sram_wdata  in  32  ignored
- inst_sram_rdata  out  32  fetched word, registered
- data_sram_en  in  1  data request
- data_sram_wen  in  4  byte enables; nonzero means write
- data_sram_addr  in  32  data address
- data_sram_wdata  in  32  store data
- data_sram_rdata  out  32  load word, registered
- stallreq  out  1  freeze the pipeline
- arid/araddr/arsize/arvalid  out  4/32/3/1  read address channel; arready in 1
- rid/rdata/rvalid  in  4/32/1  read data channel; rready out 1
- awaddr/awsize/awvalid  out  32/3/1  write address channel; awready in 1
- wdata/wstrb/wvalid  out  32/4/1  write data channel; wready in 1
- bvalid  in  1  write response; bready out 1

## Operation
- States: IDLE, D_AR, D_R, D_W, D_B, I_AR, I_R.
- Capture happens in IDLE when any `en` is 1. At the edge, the addr/wen/wdata of both ports are latched into request registers and `d_pend`/`i_pend` are set accordingly.
- Next state after capture:
  - data request with nonzero wen → D_W
  - data read → D_AR
  - otherwise (instruction only) → I_AR
- Data is always served before instruction.
- D_AR:
  - `arvalid`=1, `araddr` = latched data addr, `arid`=1, `arsize`=2.
  - On `arready`: `arvalid` drops and the state moves to D_R.
- D_R:
  - `rready`=1.
  - On `rvalid`: `data_sram_rdata` is loaded from `rdata` and `d_pend` is cleared.
  - Next state: I_AR if `i_pend`, else IDLE.
- D_W:
  - `awvalid` and `wvalid` are raised together. Each drops independently on its own ready.
  - `wstrb` = latched wen, `awsize`=2.
  - When both have handshaken (possibly in different cycles): → D_B.
- D_B:
  - `bready`=1.
  - On `bvalid`: `d_pend` is cleared.
  - Next state: I_AR if `i_pend`, else IDLE.
- I_AR / I_R: same as the data read path, with `arid`=0. The response loads `inst_sram_rdata`, then the state returns to IDLE.
- `rid` is not checked; only one transaction is outstanding at a time.
- `stallreq`, combinational:
  - IDLE: (inst_sram_en | data_sram_en) & ~rst.
  - Any other state: 1, except 0 in the cycle of the final handshake (the response that empties both pend flags).
- Core contract: request signals stay stable while stalled. The request is consumed at the edge where `stallreq`=0. A request in the next cycle is a new request.
- The rdata registers hold their value until their own next response.

## Timing
- Reset values:
  - state IDLE, all pend flags 0
  - `arvalid`/`awvalid`/`wvalid`/`rready`/`bready` = 0
  - `inst_sram_rdata` and `data_sram_rdata` = 0
  - `stallreq` = 0
- Zero-wait read, request in cycle t:
  - `arvalid` is high in t+1; `arready` at t+1.
  - `rvalid` at t+2 drops `stallreq` in t+2.
  - rdata is valid in t+3.
  - Result: 2 stall cycles (t, t+1).
- Zero-wait write: AW/W in t+1, `bvalid` t+2 → same 2 stall cycles.
- Simultaneous inst and data requests: the sequence is data, then inst. `stallreq` stays continuous until the inst response cycle.
- Ready already high when valid rises: the handshake completes in that cycle; the valid is never held an extra cycle.
- AW handshake before W (or W before AW): the completed channel's valid drops; the bridge stays in D_W until the other completes.
- Reset asserted mid-transaction: the next state is IDLE, all valids drop, and the rdata registers go to 0. A late response after reset is ignored, because `rready`/`bready` are 0.
- No combinational path from AXI inputs to AXI outputs. `stallreq` may depend combinationally on `en`, `rvalid` and `bvalid`.

## Test plan
- Inst-only read, addr 0xBFC00000, slave returns 0x3C1D0001 with arready/rvalid immediate:
  - `arvalid` high one cycle with `arid`=0.
  - `stallreq` high 2 cycles.
  - `inst_sram_rdata`=0x3C1D0001 the following cycle.
- Store, wen=4'b0011, addr 0x80000010, wdata 0x12345678; wready delayed 3 cycles after awready:
  - `wstrb`=0011.
  - `awvalid` drops after 1 cycle; `wvalid` held 4 cycles.
  - `stallreq` low only in the `bvalid` cycle.
- Simultaneous lw (data addr 0x80000020 → 0xDEADBEEF) and fetch (0xBFC00004 → 0x00000000):
  - The data AR (`arid`=1) precedes the inst AR.
  - `data_sram_rdata`=0xDEADBEEF is held while the inst read completes.
  - `stallreq` is continuous throughout.
- Back-to-back fetches 0xBFC00000 and 0xBFC00004:
  - Exactly two AR handshakes occur.
  - No duplicate issue in the cycle after the first completion.
- `rst` pulsed during D_R, `rvalid` arriving a cycle later:
  - State returns to IDLE, outputs are zero, the response is not captured, and `stallreq`=0.
